// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback,
// multiplier handshake with timeout, and exception entry through EPC and a fixed vector.
module multicycle_control_unit #(
  parameter int MULT_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       OVERFLOW,
  input  logic       ZERO,
  input  logic       mult_end,
  output logic       PC_w,
  output logic       EPC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       ALUOut_w,
  output logic       RB_w,
  output logic       AB_w,
  output logic       MEM_DATA_REG_w,
  output logic       mult_control,
  output logic       hilo_w,
  output logic [1:0] M_PC,
  output logic [1:0] M_MEM,
  output logic [1:0] M_ALUSrcA,
  output logic [1:0] M_ALUSrcB,
  output logic [1:0] M_WREG,
  output logic       M_WDATA,
  output logic [3:0] ALUOp,
  output logic [1:0] exc_sel,
  output logic [4:0] state_out
);

  localparam int CW = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_TIMEOUT - 1);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_EXEC_R     = 5'd4,
    S_WB_R       = 5'd5,
    S_EXEC_I     = 5'd6,
    S_WB_I       = 5'd7,
    S_ADDR       = 5'd8,
    S_MEM_RD     = 5'd9,
    S_MEM_WAIT   = 5'd10,
    S_WB_LW      = 5'd11,
    S_MEM_WR     = 5'd12,
    S_BRANCH     = 5'd13,
    S_JUMP       = 5'd14,
    S_MULT_START = 5'd15,
    S_MULT_WAIT  = 5'd16,
    S_EXC_SAVE   = 5'd17,
    S_EXC_RD     = 5'd18,
    S_EXC_WAIT   = 5'd19
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      exc_q, exc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  assign state_out = state_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    exc_d          = exc_q;
    PC_w           = 1'b0;
    EPC_w          = 1'b0;
    MEM_w          = 1'b0;
    IR_w           = 1'b0;
    ALUOut_w       = 1'b0;
    RB_w           = 1'b0;
    AB_w           = 1'b0;
    MEM_DATA_REG_w = 1'b0;
    mult_control   = 1'b0;
    hilo_w         = 1'b0;
    M_PC           = 2'd0;
    M_MEM          = 2'd0;
    M_ALUSrcA      = 2'd0;
    M_ALUSrcB      = 2'd0;
    M_WREG         = 2'd0;
    M_WDATA        = 1'b0;
    ALUOp          = 4'd0;
    exc_sel        = 2'd0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        M_ALUSrcB = 2'd1;
        ALUOp     = 4'd1;
        ALUOut_w  = 1'b1;
        state_d   = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        IR_w    = 1'b1;
        M_PC    = 2'd1;
        PC_w    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        AB_w      = 1'b1;
        M_ALUSrcB = 2'd3;
        ALUOp     = 4'd1;
        ALUOut_w  = 1'b1;
        case (OPCODE)
          6'h00: begin
            case (FUNCT)
              6'h20, 6'h22, 6'h24: state_d = S_EXEC_R;
              6'h18:               state_d = S_MULT_START;
              default: begin
                exc_d   = 2'd0;
                state_d = S_EXC_SAVE;
              end
            endcase
          end
          6'h08:        state_d = S_EXEC_I;
          6'h23, 6'h2B: state_d = S_ADDR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          default: begin
            exc_d   = 2'd0;
            state_d = S_EXC_SAVE;
          end
        endcase
      end
      S_EXEC_R: begin
        M_ALUSrcA = 2'd1;
        ALUOut_w  = 1'b1;
        case (FUNCT)
          6'h22:   ALUOp = 4'd2;
          6'h24:   ALUOp = 4'd3;
          default: ALUOp = 4'd1;
        endcase
        // and cannot overflow; only add/sub trap
        if (OVERFLOW && (FUNCT != 6'h24)) begin
          exc_d   = 2'd1;
          state_d = S_EXC_SAVE;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_WB_R: begin
        M_WREG  = 2'd1;
        RB_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        M_ALUSrcA = 2'd1;
        M_ALUSrcB = 2'd2;
        ALUOp     = 4'd1;
        ALUOut_w  = 1'b1;
        if (OVERFLOW) begin
          exc_d   = 2'd1;
          state_d = S_EXC_SAVE;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_WB_I: begin
        RB_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        M_ALUSrcA = 2'd1;
        M_ALUSrcB = 2'd2;
        ALUOp     = 4'd1;
        ALUOut_w  = 1'b1;
        state_d   = (OPCODE == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        M_MEM   = 2'd1;
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        M_MEM          = 2'd1;
        MEM_DATA_REG_w = 1'b1;
        state_d        = S_WB_LW;
      end
      S_WB_LW: begin
        M_WDATA = 1'b1;
        RB_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        M_MEM   = 2'd1;
        MEM_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        M_ALUSrcA = 2'd1;
        ALUOp     = 4'd2;
        M_PC      = 2'd1;
        PC_w      = ZERO ^ (OPCODE == 6'h05);
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        M_PC    = 2'd2;
        PC_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_MULT_START: begin
        mult_control = 1'b1;
        cnt_d        = '0;
        state_d      = S_MULT_WAIT;
      end
      S_MULT_WAIT: begin
        // a done pulse on the last count still completes the multiply
        if (mult_end) begin
          hilo_w  = 1'b1;
          state_d = S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          exc_d   = 2'd2;
          state_d = S_EXC_SAVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXC_SAVE: begin
        M_ALUSrcB = 2'd1;
        ALUOp     = 4'd2;
        ALUOut_w  = 1'b1;
        exc_sel   = exc_q;
        state_d   = S_EXC_RD;
      end
      S_EXC_RD: begin
        EPC_w   = 1'b1;
        M_MEM   = 2'd3;
        exc_sel = exc_q;
        state_d = S_EXC_WAIT;
      end
      S_EXC_WAIT: begin
        M_MEM     = 2'd3;
        M_ALUSrcA = 2'd2;
        PC_w      = 1'b1;
        exc_sel   = exc_q;
        state_d   = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each cycle's inputs and expected outputs are queued per scenario,
// then drained one clock at a time and compared against the full output vector.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] OPCODE, FUNCT;
  logic       OVERFLOW, ZERO, mult_end;
  logic       PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w;
  logic       mult_control, hilo_w, M_WDATA;
  logic [1:0] M_PC, M_MEM, M_ALUSrcA, M_ALUSrcB, M_WREG, exc_sel;
  logic [3:0] ALUOp;
  logic [4:0] state_out;

  multicycle_control_unit #(.MULT_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .OVERFLOW(OVERFLOW), .ZERO(ZERO), .mult_end(mult_end),
    .PC_w(PC_w), .EPC_w(EPC_w), .MEM_w(MEM_w), .IR_w(IR_w),
    .ALUOut_w(ALUOut_w), .RB_w(RB_w), .AB_w(AB_w),
    .MEM_DATA_REG_w(MEM_DATA_REG_w), .mult_control(mult_control),
    .hilo_w(hilo_w), .M_PC(M_PC), .M_MEM(M_MEM), .M_ALUSrcA(M_ALUSrcA),
    .M_ALUSrcB(M_ALUSrcB), .M_WREG(M_WREG), .M_WDATA(M_WDATA),
    .ALUOp(ALUOp), .exc_sel(exc_sel), .state_out(state_out)
  );

  typedef struct packed {
    logic pc_w, epc_w, mem_w, ir_w, aluout_w, rb_w, ab_w, mdr_w, mult_c, hilo_w;
    logic [1:0] m_pc, m_mem, srca, srcb, wreg;
    logic       wdata;
    logic [3:0] aluop;
    logic [1:0] exc;
    logic [4:0] st;
  } ov_t;

  typedef struct packed {
    logic [5:0] op, fn;
    logic ovf, zero, mend, rst, chk;
    ov_t  exp;
  } stim_t;

  localparam logic [4:0] S_RESET = 0, S_FETCH = 1, S_FW = 2, S_DEC = 3, S_EXR = 4,
    S_WBR = 5, S_EXI = 6, S_WBI = 7, S_ADDR = 8, S_MRD = 9, S_MW = 10, S_WBLW = 11,
    S_MWR = 12, S_BR = 13, S_JMP = 14, S_MS = 15, S_MWT = 16, S_ES = 17, S_ER = 18,
    S_EW = 19;

  ov_t   act;
  assign act = {PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w,
                mult_control, hilo_w, M_PC, M_MEM, M_ALUSrcA, M_ALUSrcB, M_WREG,
                M_WDATA, ALUOp, exc_sel, state_out};

  stim_t      sq[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  string      tname;
  logic [5:0] op_v, fn_v;

  // Expected outputs for a state, written from the state-by-state output list.
  function automatic ov_t mo(input logic [4:0] st, input logic [1:0] exc = 2'd0,
                             input logic zero = 1'b0, input logic mend = 1'b0,
                             input logic [3:0] rop = 4'd1, input logic bne = 1'b0);
    ov_t o;
    o = '0;
    o.st = st;
    case (st)
      S_FETCH: begin o.srcb = 1; o.aluop = 1; o.aluout_w = 1; end
      S_FW:    begin o.ir_w = 1; o.m_pc = 1; o.pc_w = 1; end
      S_DEC:   begin o.ab_w = 1; o.srcb = 3; o.aluop = 1; o.aluout_w = 1; end
      S_EXR:   begin o.srca = 1; o.aluop = rop; o.aluout_w = 1; end
      S_WBR:   begin o.wreg = 1; o.rb_w = 1; end
      S_EXI, S_ADDR: begin o.srca = 1; o.srcb = 2; o.aluop = 1; o.aluout_w = 1; end
      S_WBI:   o.rb_w = 1;
      S_MRD:   o.m_mem = 1;
      S_MW:    begin o.m_mem = 1; o.mdr_w = 1; end
      S_WBLW:  begin o.wdata = 1; o.rb_w = 1; end
      S_MWR:   begin o.m_mem = 1; o.mem_w = 1; end
      S_BR:    begin o.srca = 1; o.aluop = 2; o.m_pc = 1; o.pc_w = zero ^ bne; end
      S_JMP:   begin o.m_pc = 2; o.pc_w = 1; end
      S_MS:    o.mult_c = 1;
      S_MWT:   o.hilo_w = mend;
      S_ES:    begin o.srcb = 1; o.aluop = 2; o.aluout_w = 1; o.exc = exc; end
      S_ER:    begin o.epc_w = 1; o.m_mem = 3; o.exc = exc; end
      S_EW:    begin o.m_mem = 3; o.srca = 2; o.pc_w = 1; o.exc = exc; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic q(input ov_t e, input logic ovf = 1'b0, input logic zero = 1'b0,
                   input logic mend = 1'b0, input logic rst = 1'b0, input logic chk = 1'b1);
    stim_t s;
    s.op = op_v; s.fn = fn_v; s.ovf = ovf; s.zero = zero; s.mend = mend;
    s.rst = rst; s.chk = chk; s.exp = e;
    sq.push_back(s);
  endtask

  task automatic drain();
    stim_t s;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      reset = s.rst; OPCODE = s.op; FUNCT = s.fn;
      OVERFLOW = s.ovf; ZERO = s.zero; mult_end = s.mend;
      #1;
      if (s.chk) begin
        checks++;
        if (act !== s.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h (state got %0d expected %0d)",
                   tname, cyc, act, s.exp, act.st, s.exp.st);
        end
      end
      cyc++;
    end
  endtask

  task automatic fetch3(input logic [5:0] op, input logic [5:0] fn);
    op_v = op; fn_v = fn;
    q(mo(S_FETCH)); q(mo(S_FW)); q(mo(S_DEC));
  endtask

  task automatic exc_seq(input logic [1:0] c);
    q(mo(S_ES, c)); q(mo(S_ER, c)); q(mo(S_EW, c));
  endtask

  task automatic test_reset();
    tname = "reset";
    op_v = 6'h00; fn_v = 6'h00;
    q(mo(S_RESET), 0, 0, 0, 1'b1, 1'b0);
    q(mo(S_RESET), 0, 0, 0, 1'b1, 1'b0);
    q(mo(S_RESET));
    drain();
  endtask

  task automatic test_rtype();
    tname = "add";
    fetch3(6'h00, 6'h20); q(mo(S_EXR, 0, 0, 0, 4'd1)); q(mo(S_WBR));
    drain();
    tname = "sub";
    fetch3(6'h00, 6'h22); q(mo(S_EXR, 0, 0, 0, 4'd2)); q(mo(S_WBR));
    drain();
    tname = "and_ovf_ignored";
    fetch3(6'h00, 6'h24); q(mo(S_EXR, 0, 0, 0, 4'd3), 1'b1); q(mo(S_WBR));
    drain();
  endtask

  task automatic test_itype();
    tname = "addi";
    fetch3(6'h08, 6'h11); q(mo(S_EXI)); q(mo(S_WBI));
    drain();
    tname = "lw";
    fetch3(6'h23, 6'h04); q(mo(S_ADDR), 1'b1); q(mo(S_MRD)); q(mo(S_MW)); q(mo(S_WBLW));
    drain();
    tname = "sw";
    fetch3(6'h2B, 6'h08); q(mo(S_ADDR)); q(mo(S_MWR));
    drain();
  endtask

  task automatic test_branch_jump();
    logic z, b;
    for (int i = 0; i < 4; i++) begin
      z = i[0]; b = i[1];
      tname = b ? "bne" : "beq";
      fetch3(b ? 6'h05 : 6'h04, 6'h3C);
      q(mo(S_BR, 0, z, 0, 4'd1, b), 1'b0, z);
      drain();
    end
    tname = "jump";
    fetch3(6'h02, 6'h00); q(mo(S_JMP));
    drain();
  endtask

  task automatic test_mult();
    tname = "mult_done33";
    fetch3(6'h00, 6'h18); q(mo(S_MS));
    for (int i = 0; i < 32; i++) q(mo(S_MWT));
    q(mo(S_MWT, 0, 0, 1'b1), 0, 0, 1'b1);
    drain();
    tname = "mult_timeout";
    fetch3(6'h00, 6'h18); q(mo(S_MS));
    for (int i = 0; i < 64; i++) q(mo(S_MWT));
    exc_seq(2'd2);
    drain();
    tname = "mult_done_last";
    fetch3(6'h00, 6'h18); q(mo(S_MS));
    for (int i = 0; i < 63; i++) q(mo(S_MWT));
    q(mo(S_MWT, 0, 0, 1'b1), 0, 0, 1'b1);
    q(mo(S_FETCH));
    drain();
    op_v = 6'h3F; fn_v = 6'h00;
    q(mo(S_FW)); q(mo(S_DEC)); exc_seq(2'd0);
    drain();
  endtask

  task automatic test_exceptions();
    tname = "addi_ovf";
    fetch3(6'h08, 6'h00); q(mo(S_EXI), 1'b1); exc_seq(2'd1);
    drain();
    tname = "add_ovf";
    fetch3(6'h00, 6'h20); q(mo(S_EXR, 0, 0, 0, 4'd1), 1'b1); exc_seq(2'd1);
    drain();
    tname = "bad_opcode";
    fetch3(6'h3F, 6'h20); exc_seq(2'd0);
    drain();
    tname = "bad_funct";
    fetch3(6'h00, 6'h21); exc_seq(2'd0);
    drain();
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid_wbr";
    fetch3(6'h00, 6'h20); q(mo(S_EXR)); q(mo(S_WBR), 0, 0, 0, 1'b1); q(mo(S_RESET));
    drain();
    tname = "reset_mid_mult";
    fetch3(6'h00, 6'h18); q(mo(S_MS));
    for (int i = 0; i < 4; i++) q(mo(S_MWT));
    q(mo(S_MWT), 0, 0, 0, 1'b1); q(mo(S_RESET));
    drain();
    tname = "reset_mid_exc";
    fetch3(6'h3F, 6'h00); q(mo(S_ES, 2'd0)); q(mo(S_ER, 2'd0), 0, 0, 0, 1'b1);
    q(mo(S_RESET)); q(mo(S_FETCH));
    drain();
  endtask

  initial begin
    reset = 1'b1; OPCODE = '0; FUNCT = '0; OVERFLOW = 1'b0; ZERO = 1'b0; mult_end = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_branch_jump();
    test_mult();
    test_exceptions();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
